ram_ctrl_seq: RTL

//  Command sequencer directly upstream of the 4x4-bit RAM + accumulator stage.

---
 rtl/ram_ctrl_pkg.sv | 24 ++
 rtl/ram_ctrl_phase_cnt.sv | 28 ++
 rtl/ram_ctrl_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM command sequencer: command op encodings,
// FSM state encoding and the phase-counter width helper.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } opT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STRB,
        ST_HOLD
    } stateT;

    // Width needed to count down a SETUP/HOLD window of holdCyc cycles.
    function automatic int cntWidth(input int holdCyc);
        return (holdCyc < 1) ? 1 : $clog2(holdCyc + 1);
    endfunction

endpackage

// File: rtl/ram_ctrl_phase_cnt.sv
// Loadable down-counter timing the SETUP/HOLD windows; zero marks the
// last cycle of the current window.
module ram_ctrl_phase_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ram_ctrl_seq.sv
// Command sequencer feeding the 4x4 RAM + accumulator stage with glitch-free
// one-cycle strobes. Optional CLEAR command enabled by macro RAM_CTRL_CLEAR_EN.
module ram_ctrl_seq
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 2,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    output logic              acc_ld,
    output logic              busy,
    output logic              done
);

`ifdef RAM_CTRL_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    localparam int                CNT_W     = cntWidth(HOLD_CYC);
    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    stateT            state, stateNext;
    opT               op;
    logic             cmdRuns, cmdClear;
    logic             isLoad, isClear;
    logic             moreItems, nextItem;
    logic             cntLoad, cntZero;
    logic [CNT_W-1:0] cntLoadVal;

    assign op        = opT'(cmd_op);
    assign cmdClear  = CLEAR_EN && (op == OP_CLEAR);
    assign cmdRuns   = (op == OP_WRITE) || (op == OP_LOAD) || cmdClear;
    assign moreItems = isClear && (ram_addr != ADDR_LAST);

    ram_ctrl_phase_cnt #(.W(CNT_W)) uPhaseCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .loadVal (cntLoadVal),
        .zero    (cntZero)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stateNext  = state;
        cntLoad    = 1'b0;
        cntLoadVal = WIN_LAST;
        nextItem   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cntLoad = 1'b1;
                    if (cmdRuns) begin
                        stateNext = ST_SETUP;
                    end else begin
                        // NOP spends a single HOLD cycle so done still pulses.
                        stateNext  = ST_HOLD;
                        cntLoadVal = '0;
                    end
                end
            end
            ST_SETUP: begin
                if (cntZero) stateNext = ST_STRB;
            end
            ST_STRB: begin
                stateNext = ST_HOLD;
                cntLoad   = 1'b1;
            end
            ST_HOLD: begin
                if (cntZero) begin
                    if (moreItems) begin
                        stateNext = ST_SETUP;
                        cntLoad   = 1'b1;
                        nextItem  = 1'b1;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ram_addr <= '0;
            ram_d    <= '0;
            ram_we   <= 1'b0;
            acc_ld   <= 1'b0;
            isLoad   <= 1'b0;
            isClear  <= 1'b0;
        end else begin
            state  <= stateNext;
            // Strobes are registered decodes of the next state: one clean cycle each.
            ram_we <= (stateNext == ST_STRB) && !isLoad;
            acc_ld <= (stateNext == ST_STRB) && isLoad;
            if (state == ST_IDLE && cmd_valid) begin
                isLoad  <= (op == OP_LOAD);
                isClear <= cmdClear;
                if (cmdClear) begin
                    ram_addr <= '0;
                    ram_d    <= '0;
                end else if (op == OP_WRITE) begin
                    ram_addr <= cmd_addr;
                    ram_d    <= cmd_data;
                end else if (op == OP_LOAD) begin
                    ram_addr <= cmd_addr;
                end
            end else if (nextItem) begin
                // ram_addr doubles as the CLEAR address counter.
                ram_addr <= ram_addr + ADDR_W'(1);
            end
        end
    end

    assign done      = (state == ST_HOLD) && cntZero && !moreItems;
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign busy      = ~cmd_ready;

endmodule
